mem_port_arbiter: RTL and testbench

- Shares one external memory/MMIO bus between two requesters: the IF-stage instruction fetch port and the MEM-stage data port.
- Sequences each bus transaction with a ready handshake, the same semantics as MIO_ready.
- Drives a pipeline stall while any request is outstanding.
- Sits between the pipelined CPU core and the bus / memory-IO controller.

---
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory/MMIO bus between the IF-stage fetch port and the
//   MEM-stage data port. Each bus transaction runs a ready handshake. The
//   pipeline stalls while either request is outstanding.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   if_req_i/if_addr_i     fetch request (held until if_ack_o) and PC
//   if_ack_o/if_rdata_o    one-cycle fetch completion pulse + instruction
//   d_req_i/d_we_i/...     data request (held until d_ack_o): we, addr,
//                          wdata, dmtype
//   d_ack_o/d_rdata_o      one-cycle data completion pulse + load data
//   bus_*_o                registered bus command; bus_req_o is high while
//                          a transaction is in flight
//   bus_ready_i/rdata_i    target completion handshake + read data
//   stall_o                freeze the pipeline
//   timeout_err_o          pulses with the ack of a timed-out transaction
module mem_port_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 255,
  parameter logic [31:0] ERR_DATA     = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [2:0]  d_dmtype_i,
  output logic        d_ack_o,
  output logic [31:0] d_rdata_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [2:0]  bus_dmtype_o,
  input  logic        bus_ready_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stall_o,
  output logic        timeout_err_o
);

  localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GRANT_IF, GRANT_D} state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  dmtype;
  } bus_cmd_t;

  state_e        state_q;
  bus_cmd_t      cmd_q;
  logic          bus_req_q;
  logic          if_ack_q, d_ack_q, terr_q;
  logic [31:0]   if_rdata_q, d_rdata_q;
  logic [SW-1:0] streak_q;
  logic [TW-1:0] tmo_q;

  logic          if_pend_d, d_pend_d, ack_busy_d;
  logic          grant_d_d, grant_if_d, done_d;
  logic [31:0]   rdata_d;

  // A requester whose ack is pulsing this cycle is not pending any more.
  assign if_pend_d  = if_req_i & ~if_ack_q;
  assign d_pend_d   = d_req_i & ~d_ack_q;
  // The ack cycle is a dead IDLE cycle: nothing is granted in it, which
  // gives each transaction a minimum occupancy of three cycles.
  assign ack_busy_d = if_ack_q | d_ack_q;
  assign grant_d_d  = ~ack_busy_d & d_pend_d &
                      (~if_pend_d | (streak_q < SW'(MAX_D_STREAK)));
  assign grant_if_d = ~ack_busy_d & if_pend_d & ~grant_d_d;

  // Completion on ready, or on the last permitted waiting cycle. Ready wins
  // over the timeout when both land in the same cycle.
  assign done_d  = bus_ready_i | (tmo_q == TW'(TIMEOUT - 1));
  assign rdata_d = bus_ready_i ? bus_rdata_i : ERR_DATA;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      bus_req_q  <= 1'b0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      terr_q     <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      streak_q   <= '0;
      tmo_q      <= '0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      terr_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_d_d) begin
            cmd_q     <= '{we: d_we_i, addr: d_addr_i, wdata: d_wdata_i, dmtype: d_dmtype_i};
            bus_req_q <= 1'b1;
            tmo_q     <= '0;
            state_q   <= GRANT_D;
            // Count data grants that bypass a waiting fetch.
            if (!if_pend_d)
              streak_q <= '0;
            else if (streak_q != SW'(MAX_D_STREAK))
              streak_q <= streak_q + SW'(1);
          end else if (grant_if_d) begin
            cmd_q     <= '{we: 1'b0, addr: if_addr_i, wdata: 32'h0, dmtype: 3'b010};
            bus_req_q <= 1'b1;
            tmo_q     <= '0;
            streak_q  <= '0;
            state_q   <= GRANT_IF;
          end
        end
        GRANT_IF, GRANT_D: begin
          if (done_d) begin
            bus_req_q <= 1'b0;
            terr_q    <= ~bus_ready_i;
            state_q   <= IDLE;
            if (state_q == GRANT_IF) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= rdata_d;
            end else begin
              d_ack_q <= 1'b1;
              if (!cmd_q.we) d_rdata_q <= rdata_d;
            end
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_ack_o      = if_ack_q;
  assign if_rdata_o    = if_rdata_q;
  assign d_ack_o       = d_ack_q;
  assign d_rdata_o     = d_rdata_q;
  assign bus_req_o     = bus_req_q;
  assign bus_we_o      = cmd_q.we;
  assign bus_addr_o    = cmd_q.addr;
  assign bus_wdata_o   = cmd_q.wdata;
  assign bus_dmtype_o  = cmd_q.dmtype;
  assign timeout_err_o = terr_q;
  assign stall_o       = if_pend_d | d_pend_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int MAXS = 4;
  localparam int TMO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic clk, rst;
  logic if_req, if_ack, d_req, d_we, d_ack, bus_req, bus_we, bus_ready, stall, terr;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, bus_addr, bus_wdata, bus_rdata;
  logic [2:0] d_dmtype, bus_dmtype;

  mem_port_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_dmtype_i(d_dmtype), .d_ack_o(d_ack), .d_rdata_o(d_rdata),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
    .bus_dmtype_o(bus_dmtype), .bus_ready_i(bus_ready), .bus_rdata_i(bus_rdata),
    .stall_o(stall), .timeout_err_o(terr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction-level view: who owns the bus, how many grant cycles it has
  // used, what was latched at grant time, and what each port last returned.
  int          m_owner = 0;   // 0 none, 1 fetch, 2 data
  int          m_wait  = 0;
  int          m_run   = 0;   // data grants in a row while a fetch waited
  bit          m_valid = 0;
  bit          m_was_ack;
  logic        m_we, m_ifa, m_da, m_te;
  logic [31:0] m_addr, m_wdata, m_ifr, m_dr, m_rd;
  logic [2:0]  m_dm;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = 0; m_wait = 0; m_run = 0; m_valid = 1;
      m_we = 0; m_addr = 0; m_wdata = 0; m_dm = 0;
      m_ifa = 0; m_da = 0; m_te = 0; m_ifr = 0; m_dr = 0;
    end else if (m_valid) begin
      m_was_ack = m_ifa | m_da;
      m_ifa = 0; m_da = 0; m_te = 0;
      if (m_owner == 0) begin
        if (!m_was_ack) begin
          if (d_req && (!if_req || m_run < MAXS)) begin
            m_owner = 2; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_dm = d_dmtype;
            m_run = if_req ? ((m_run < MAXS) ? m_run + 1 : MAXS) : 0;
          end else if (if_req) begin
            m_owner = 1; m_we = 0; m_addr = if_addr; m_wdata = 0; m_dm = 3'b010; m_run = 0;
          end
          m_wait = 0;
        end
      end else begin
        m_wait++;
        if (bus_ready || m_wait == TMO) begin
          m_rd = bus_ready ? bus_rdata : ERR;
          m_te = !bus_ready;
          if (m_owner == 1) begin m_ifa = 1; m_ifr = m_rd; end
          else begin m_da = 1; if (!m_we) m_dr = m_rd; end
          m_owner = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("bus_req", {31'b0, bus_req}, {31'b0, m_owner != 0});
      chk("if_ack", {31'b0, if_ack}, {31'b0, m_ifa});
      chk("d_ack", {31'b0, d_ack}, {31'b0, m_da});
      chk("timeout_err", {31'b0, terr}, {31'b0, m_te});
      chk("if_rdata", if_rdata, m_ifr);
      chk("d_rdata", d_rdata, m_dr);
      chk("stall", {31'b0, stall}, {31'b0, (if_req & ~m_ifa) | (d_req & ~m_da)});
      if (m_owner != 0) begin
        chk("bus_we", {31'b0, bus_we}, {31'b0, m_we});
        chk("bus_addr", bus_addr, m_addr);
        chk("bus_dmtype", {29'b0, bus_dmtype}, {29'b0, m_dm});
        if (m_owner == 2) chk("bus_wdata", bus_wdata, m_wdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(); @(posedge clk); #1; endtask
  task automatic neg();  @(negedge clk);     endtask

  int dcyc, icyc, g, hi, pat, lastc;
  bit ai, done;
  int seq[$];
  int rdy_pct;

  initial begin
    rst = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    d_dmtype = 0; bus_ready = 0; bus_rdata = 0;
    step(); step();
    neg();
    chk("rst_bus_req", {31'b0, bus_req}, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_d_rdata", d_rdata, 0);
    step(); rst = 0;

    // Fetch only
    step(); if_req = 1; if_addr = 32'h100; bus_ready = 0;
    neg(); chk("t1_bus_idle", {31'b0, bus_req}, 0); chk("t1_stall", {31'b0, stall}, 1);
    step(); bus_ready = 1; bus_rdata = 32'h0050_0093;
    neg(); chk("t1_bus_req", {31'b0, bus_req}, 1); chk("t1_bus_addr", bus_addr, 32'h100);
    chk("t1_bus_we", {31'b0, bus_we}, 0);
    step(); bus_ready = 0;
    neg(); chk("t1_if_ack", {31'b0, if_ack}, 1); chk("t1_if_rdata", if_rdata, 32'h0050_0093);
    chk("t1_stall_ack", {31'b0, stall}, 0);
    step(); if_req = 0;
    neg(); chk("t1_ack_pulse", {31'b0, if_ack}, 0);

    // Simultaneous requests: data first, then fetch
    step(); bus_ready = 1; bus_rdata = 32'h1111_1111;
    if_req = 1; if_addr = 32'h200; d_req = 1; d_we = 0; d_addr = 32'h2000; d_dmtype = 3'b010;
    dcyc = -1; icyc = -1;
    for (int c = 0; c < 12; c++) begin
      neg();
      if (d_ack && dcyc < 0) dcyc = c;
      if (if_ack && icyc < 0) icyc = c;
      if (icyc < 0 || icyc == c) chk("t2_stall", {31'b0, stall}, (icyc == c) ? 0 : 1);
      step();
      if (dcyc >= 0) d_req = 0;
      if (icyc >= 0) if_req = 0;
    end
    chk("t2_d_ack_cycle", dcyc, 2);
    chk("t2_if_ack_cycle", icyc, 5);

    // Starvation guard
    step(); bus_ready = 1; bus_rdata = 32'h2222_2222;
    d_req = 1; d_we = 0; d_addr = 32'h4000; if_req = 1; if_addr = 32'h300;
    seq.delete(); icyc = -1; lastc = -1;
    for (int c = 0; c < 40; c++) begin
      neg();
      ai = if_ack;
      if (d_ack) seq.push_back(2);
      if (if_ack) begin seq.push_back(1); icyc = c; end
      if (seq.size() == 6 && lastc < 0) lastc = c;
      step();
      if (ai) if_req = 0;
      if (seq.size() >= 6) begin d_req = 0; break; end
    end
    pat = 0;
    foreach (seq[i]) pat = pat * 10 + seq[i];
    chk("t3_ack_order", pat, 222212);
    chk("t3_if_ack_cycle", icyc, 14);
    chk("t3_resume_cycle", lastc, 17);

    // Store
    step(); bus_ready = 0; d_req = 1; d_we = 1; d_addr = 32'hFFFF_0000;
    d_wdata = 32'hA5A5_A5A5; d_dmtype = 3'b000;
    neg();
    step(); bus_ready = 1; bus_rdata = 32'h9999_9999;
    neg(); chk("t4_bus_we", {31'b0, bus_we}, 1); chk("t4_bus_addr", bus_addr, 32'hFFFF_0000);
    chk("t4_bus_wdata", bus_wdata, 32'hA5A5_A5A5); chk("t4_bus_dmtype", {29'b0, bus_dmtype}, 0);
    step(); bus_ready = 0;
    neg(); chk("t4_d_ack", {31'b0, d_ack}, 1); chk("t4_d_rdata_kept", d_rdata, 32'h2222_2222);
    step(); d_req = 0; d_we = 0;

    // Timeout
    step(); d_req = 1; d_addr = 32'h3000; d_dmtype = 3'b010; bus_ready = 0;
    hi = 0; dcyc = -1;
    for (int c = 0; c < 20; c++) begin
      neg();
      if (bus_req) hi++;
      if (d_ack) begin
        dcyc = c;
        chk("t5_terr", {31'b0, terr}, 1); chk("t5_d_rdata", d_rdata, ERR);
        chk("t5_bus_req_ack", {31'b0, bus_req}, 0);
      end
      step();
      if (dcyc >= 0) begin d_req = 0; break; end
    end
    neg(); chk("t5_bus_req_after", {31'b0, bus_req}, 0);
    chk("t5_grant_cycles", hi, TMO);
    chk("t5_ack_cycle", dcyc, TMO + 1);

    // Ready in the timeout cycle wins
    step(); d_req = 1; d_addr = 32'h3004; bus_ready = 0; bus_rdata = 32'h1234_5678;
    g = 0; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      neg();
      if (d_ack) begin
        done = 1;
        chk("t5b_terr", {31'b0, terr}, 0); chk("t5b_d_rdata", d_rdata, 32'h1234_5678);
      end
      step();
      if (bus_req) begin g++; bus_ready = (g == TMO); end else bus_ready = 0;
    end
    chk("t5b_done", {31'b0, done}, 1); chk("t5b_grant_cycles", g, TMO);
    d_req = 0; bus_ready = 0;

    // Reset mid-transaction
    step(); d_req = 1; d_addr = 32'h5000; bus_ready = 0; g = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (bus_req) g++;
      if (g == 3) begin rst = 1; break; end
    end
    chk("t6_wait_reached", g, 3);
    step(); rst = 0; d_req = 0;
    neg(); chk("t6_bus_req", {31'b0, bus_req}, 0); chk("t6_d_ack", {31'b0, d_ack}, 0);
    chk("t6_if_ack", {31'b0, if_ack}, 0); chk("t6_bus_addr", bus_addr, 0);
    chk("t6_d_rdata", d_rdata, 0);
    step(); if_req = 1; if_addr = 32'h400; bus_ready = 1; bus_rdata = 32'h0BAD_F00D;
    icyc = -1;
    for (int c = 0; c < 10; c++) begin
      neg();
      if (if_ack) begin icyc = c; chk("t6_if_rdata", if_rdata, 32'h0BAD_F00D); end
      step();
      if (icyc >= 0) begin if_req = 0; break; end
    end
    chk("t6_if_ack_cycle", icyc, 2);

    // Randomized traffic, checked every cycle by the model
    rdy_pct = 70;
    for (int c = 0; c < 4000; c++) begin
      step();
      if (c % 500 == 0) rdy_pct = (rdy_pct == 70) ? 3 : 70;
      bus_ready = ($urandom_range(99) < rdy_pct);
      bus_rdata = $urandom;
      rst = ($urandom_range(399) == 0);
      if (if_req && if_ack) begin
        if ($urandom_range(1) == 0) if_req = 0; else if_addr = $urandom;
      end else if (!if_req && $urandom_range(2) == 0) begin
        if_req = 1; if_addr = $urandom;
      end
      if (d_req && d_ack) begin
        if ($urandom_range(1) == 0) d_req = 0;
        else begin d_we = $urandom_range(1); d_addr = $urandom; d_wdata = $urandom; d_dmtype = 3'($urandom_range(7)); end
      end else if (!d_req && $urandom_range(2) == 0) begin
        d_req = 1; d_we = $urandom_range(1); d_addr = $urandom; d_wdata = $urandom;
        d_dmtype = 3'($urandom_range(7));
      end
    end
    step(); rst = 0;
    neg();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
